// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the core and the multiply/divide unit.
// Rev 1.0
`default_nettype none

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct, a, b,
        input  busy, stall, done, hi, lo, result
    );

    modport slave (
        input  start, funct, a, b,
        output busy, stall, done, hi, lo, result
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with private HI/LO; MTHI/MTLO under MULDIV_MTHILO_EN.
// Rev 1.0
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam int         CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_LOOP = CW'(WIDTH - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   hi_val;
    logic [WIDTH-1:0]   lo_val;
    logic               done_val;

    // Operation decode: 0x18..0x1B are the arithmetic ops, bit0 = unsigned, bit1 = divide.
    logic is_arith;
    logic is_signed_op;
    logic is_move;
    assign is_arith     = (bus.funct[5:2] == 4'b0110);
    assign is_signed_op = ~bus.funct[0];
`ifdef MULDIV_MTHILO_EN
    assign is_move = (bus.funct[5:2] == 4'b0100);
`else
    assign is_move = (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
`endif

    // Magnitudes fit in WIDTH unsigned bits: |most-negative| = 2^(WIDTH-1).
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = is_signed_op & bus.a[WIDTH-1];
    assign b_neg = is_signed_op & bus.b[WIDTH-1];
    assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

    // One shift-add multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // One restoring-divide step: acc = {partial remainder, dividend/quotient bits}.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] step_next;
    assign step_next = is_div ? div_next : mul_next;

    // FIX performs the final iteration together with the sign correction.
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   quo_mag, rem_mag, fix_quo, fix_rem;
    assign fix_prod = neg_res ? (~step_next + 1'b1) : step_next;
    assign quo_mag  = step_next[WIDTH-1:0];
    assign rem_mag  = step_next[2*WIDTH-1:WIDTH];
    assign fix_quo  = b_zero ? {WIDTH{1'b1}} : (neg_res ? (~quo_mag + 1'b1) : quo_mag);
    assign fix_rem  = neg_rem ? (~rem_mag + 1'b1) : rem_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            hi_val   <= '0;
            lo_val   <= '0;
            done_val <= 1'b0;
        end else begin
            done_val <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && is_arith) begin
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        opb     <= b_mag;
                        is_div  <= bus.funct[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        b_zero  <= (bus.b == '0);
                        count   <= '0;
                        state   <= bus.funct[1] ? S_DIV : S_MUL;
                    end
`ifdef MULDIV_MTHILO_EN
                    else if (bus.start && bus.funct == F_MTHI) begin
                        hi_val <= bus.a;
                    end else if (bus.start && bus.funct == F_MTLO) begin
                        lo_val <= bus.a;
                    end
`endif
                end
                S_MUL, S_DIV: begin
                    acc   <= step_next;
                    count <= count + 1'b1;
                    if (count == LAST_LOOP) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi_val <= fix_rem;
                        lo_val <= fix_quo;
                    end else begin
                        hi_val <= fix_prod[2*WIDTH-1:WIDTH];
                        lo_val <= fix_prod[WIDTH-1:0];
                    end
                    done_val <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.stall  = bus.busy && bus.start && (is_arith || is_move);
    assign bus.done   = done_val;
    assign bus.hi     = hi_val;
    assign bus.lo     = lo_val;
    assign bus.result = (bus.funct == F_MFHI) ? hi_val : lo_val;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO from plain signed/unsigned 64-bit arithmetic.
    task automatic model_op(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (f)
            F_MULTU: begin
                u = {32'b0, av} * {32'b0, bv};
                m_hi = u[63:32]; m_lo = u[31:0];
            end
            F_MULT: begin
                u = sa * sb;
                m_hi = u[63:32]; m_lo = u[31:0];
            end
            F_DIVU: begin
                if (bv == 0) begin m_hi = av; m_lo = '1; end
                else begin m_lo = av / bv; m_hi = av % bv; end
            end
            F_DIV: begin
                if (bv == 0) begin m_hi = av; m_lo = '1; end
                else begin
                    q = sa / sb; r = sa % sb;
                    u = q; m_lo = u[31:0];
                    u = r; m_hi = u[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Drives an op in the current cycle and returns in its done cycle (or after a bound).
    task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic busy1);
        bus.start = 1'b1; bus.funct = f; bus.a = av; bus.b = bv;
        tick();
        bus.start = 1'b0;
        busy1 = bus.busy;
        lat = 1;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        model_op(f, av, bv);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: pick = '0;
            1: pick = 32'h8000_0000;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'h1;
            default: pick = $urandom;
        endcase
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    endtask

    task automatic test_latency();
        int lat; logic b1;
        issue(F_MULTU, 32'hFFFF_FFFF, 32'h2, lat, b1);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL lat_busy_first got=%b exp=1", b1); end
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL lat_done_cycle got=%0d exp=%0d", lat, W + 1); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lat_busy_at_done got=%b exp=0", bus.busy); end
        checks++; if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE)
            begin errors++; $display("FAIL lat_multu got=%h_%h exp=00000001_fffffffe", bus.hi, bus.lo); end
    endtask

    task automatic test_directed();
        logic [5:0]   tf[6] = '{F_MULT, F_DIV, F_DIVU, F_DIVU, F_DIV, F_MULT};
        logic [W-1:0] ta[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] tb[6] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
        int lat; logic b1;
        for (int i = 0; i < 6; i++) begin
            issue(tf[i], ta[i], tb[i], lat, b1);
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
            checks++; if (bus.hi !== m_hi || bus.lo !== m_lo)
                begin errors++; $display("FAIL dir%0d_hilo got=%h_%h exp=%h_%h", i, bus.hi, bus.lo, m_hi, m_lo); end
            if (i == 0) begin
                bus.start = 1'b1; bus.funct = F_MFHI;
                #1;
                checks++; if (bus.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi_result got=%h exp=ffffffff", bus.result); end
                checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mfhi_stall got=%b exp=0", bus.stall); end
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [5:0] f; logic [W-1:0] av, bv; int lat; logic b1;
        for (int i = 0; i < 40; i++) begin
            f = ops[$urandom_range(0, 3)];
            av = pick(); bv = pick();
            issue(f, av, bv, lat, b1);
            checks++; if (lat !== W + 1 || b1 !== 1'b1)
                begin errors++; $display("FAIL rnd%0d_timing lat=%0d busy1=%b exp=%0d,1", i, lat, b1, W + 1); end
            checks++; if (bus.hi !== m_hi || bus.lo !== m_lo)
                begin errors++; $display("FAIL rnd%0d_hilo f=%h a=%h b=%h got=%h_%h exp=%h_%h", i, f, av, bv, bus.hi, bus.lo, m_hi, m_lo); end
            bus.funct = ($urandom_range(0, 1) != 0) ? F_MFHI : F_MFLO;
            #1;
            checks++; if (bus.result !== ((bus.funct == F_MFHI) ? m_hi : m_lo))
                begin errors++; $display("FAIL rnd%0d_result got=%h", i, bus.result); end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] av, bv; int cyc; int bad;
        av = $urandom; bv = $urandom;
        bus.start = 1'b1; bus.funct = F_MULTU; bus.a = av; bus.b = bv;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1; bus.funct = F_MFLO;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_mflo got=%b exp=1", bus.stall); end
        cyc = 5; bad = 0;
        while (bus.busy && cyc < 100) begin
            if (bus.stall !== 1'b1) bad++;
            tick();
            cyc++;
        end
        model_op(F_MULTU, av, bv);
        checks++; if (bad !== 0 || cyc !== W + 1) begin errors++; $display("FAIL stall_hold bad=%0d release=%0d exp=0,%0d", bad, cyc, W + 1); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", bus.stall); end
        checks++; if (bus.result !== m_lo) begin errors++; $display("FAIL stall_result got=%h exp=%h", bus.result, m_lo); end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        int pulses;
        bus.start = 1'b1; bus.funct = F_DIV; bus.a = $urandom; bus.b = $urandom | 32'h1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL midreset_ctl busy=%b done=%b exp=0,0", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
            begin errors++; $display("FAIL midreset_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus.done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", pulses); end
    endtask

    task automatic test_mthilo_and_ignored();
        logic [W-1:0] exp_hi, exp_lo; int lat; logic b1;
        issue(F_MULTU, 32'h0001_0001, 32'h0003_0000, lat, b1);
        exp_hi = m_hi; exp_lo = m_lo;
        bus.start = 1'b1; bus.funct = F_MTHI; bus.a = 32'h1234_5678;
        tick();
        bus.funct = F_MTLO; bus.a = 32'h9ABC_DEF0;
        tick();
        bus.start = 1'b0;
`ifdef MULDIV_MTHILO_EN
        exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
`endif
        m_hi = exp_hi; m_lo = exp_lo;
        checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo)
            begin errors++; $display("FAIL mthilo_write got=%h_%h exp=%h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL mthilo_ctl busy=%b done=%b exp=0,0", bus.busy, bus.done); end
        bus.start = 1'b1; bus.funct = 6'h20; bus.a = $urandom; bus.b = $urandom;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
            begin errors++; $display("FAIL ignored_funct busy=%b got=%h_%h exp=0,%h_%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo); end
        bus.start = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.funct = F_MTHI;
        #1;
`ifdef MULDIV_MTHILO_EN
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall got=%b exp=1", bus.stall); end
`else
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_busy_stall got=%b exp=0", bus.stall); end
`endif
        bus.funct = 6'h21;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ignored_busy_stall got=%b exp=0", bus.stall); end
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin tick(); lat++; end
        model_op(F_DIVU, 32'd100, 32'd7);
        checks++; if (bus.hi !== m_hi || bus.lo !== m_lo)
            begin errors++; $display("FAIL divu_after_ignored got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_stall();
        test_reset_midop();
        test_mthilo_and_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
